mesh_2x2: RTL and testbench

MESH_2X2 -- requirements
Module: mesh_2x2

---
 rtl/noc_pkg.sv | 47 ++++
 rtl/mesh_2x2_if.sv | 30 +++
 rtl/noc_router.sv | 119 +++++++++++
 rtl/mesh_2x2.sv | 80 ++++++++
 tb/tb_mesh_2x2.sv | 307 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/noc_pkg.sv
// Shared flit/config layouts, sizes, port indices and the XY route function
// for the 2x2 mesh NoC.
package noc_pkg;

    localparam int unsigned FLIT_W    = 18;
    localparam int unsigned DATA_W    = 9;
    localparam int unsigned CFG_W     = 11;
    localparam int unsigned NODE_W    = 2;
    localparam int unsigned RSV_W     = 4;
    localparam int unsigned NUM_NODES = 4;
    localparam int unsigned NUM_IN    = 4;
    localparam int unsigned NUM_OUT   = 3;

    // Input buffer indices; also the round-robin order
    localparam logic [1:0] IN_LOCAL = 2'd0;
    localparam logic [1:0] IN_EXT   = 2'd1;
    localparam logic [1:0] IN_X     = 2'd2;
    localparam logic [1:0] IN_Y     = 2'd3;

    localparam logic [1:0] OUT_X     = 2'd0;
    localparam logic [1:0] OUT_Y     = 2'd1;
    localparam logic [1:0] OUT_EJECT = 2'd2;

    // Flit fields: [17] valid, [16:15] src, [14:13] dest, [12:9] rsv, [8:0] data
    typedef struct packed {
        logic              valid;
        logic [NODE_W-1:0] src;
        logic [NODE_W-1:0] dest;
        logic [RSV_W-1:0]  rsv;
        logic [DATA_W-1:0] data;
    } flit_t;

    // Processor request: [10:9] dest, [8:0] data
    typedef struct packed {
        logic [NODE_W-1:0] dest;
        logic [DATA_W-1:0] data;
    } cfg_t;

    // Node id bit 0 is x, bit 1 is y; fix x first, then y, then eject
    function automatic logic [1:0] xy_route(input logic [NODE_W-1:0] own,
                                            input logic [NODE_W-1:0] dest);
        if (dest[0] != own[0]) return OUT_X;
        if (dest[1] != own[1]) return OUT_Y;
        return OUT_EJECT;
    endfunction

endpackage

// File: rtl/mesh_2x2_if.sv
// Processor/external-facing bundle of the 2x2 mesh.
interface mesh_2x2_if;
    import noc_pkg::*;

    logic [FLIT_W-1:0]    r0_input, r1_input, r2_input, r3_input;
    logic [CFG_W-1:0]     p0_configure, p1_configure, p2_configure, p3_configure;
    logic                 block_all_paths;
    logic [NUM_NODES-1:0] processor_ready_signals;
    logic [DATA_W-1:0]    p0_recieve_data, p1_recieve_data, p2_recieve_data, p3_recieve_data;
    logic [FLIT_W-1:0]    r0_output, r1_output, r2_output, r3_output;

    modport master (
        output r0_input, r1_input, r2_input, r3_input,
        output p0_configure, p1_configure, p2_configure, p3_configure,
        output block_all_paths,
        input  processor_ready_signals,
        input  p0_recieve_data, p1_recieve_data, p2_recieve_data, p3_recieve_data,
        input  r0_output, r1_output, r2_output, r3_output
    );

    modport slave (
        input  r0_input, r1_input, r2_input, r3_input,
        input  p0_configure, p1_configure, p2_configure, p3_configure,
        input  block_all_paths,
        output processor_ready_signals,
        output p0_recieve_data, p1_recieve_data, p2_recieve_data, p3_recieve_data,
        output r0_output, r1_output, r2_output, r3_output
    );

endinterface

// File: rtl/noc_router.sv
// One mesh router: four one-flit input buffers, XY routing and a
// round-robin arbiter per output (X link, Y link, eject).
module noc_router
    import noc_pkg::*;
#(
    parameter logic [NODE_W-1:0] NODE_ID = '0
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              block,
    input  cfg_t              cfg,
    input  flit_t             ext_in,
    input  flit_t             x_in,
    input  logic              x_in_load,
    input  flit_t             y_in,
    input  logic              y_in_load,
    input  logic              x_nb_empty,
    input  logic              y_nb_empty,
    output flit_t             x_out_c,
    output logic              x_out_load_c,
    output flit_t             y_out_c,
    output logic              y_out_load_c,
    output logic              local_empty_c,
    output logic              x_empty_c,
    output logic              y_empty_c,
    output logic [DATA_W-1:0] eject_data,
    output flit_t             eject_flit
);

    flit_t                         buf_q [NUM_IN];
    flit_t                         buf_d [NUM_IN];
    logic [1:0]                    ptr_q [NUM_OUT];
    logic [1:0]                    ptr_d [NUM_OUT];
    logic [1:0]                    gnt_idx [NUM_OUT];
    logic [NUM_OUT-1:0]            gnt_valid;
    logic [NUM_OUT-1:0]            out_ready;
    logic [NUM_OUT-1:0][NUM_IN-1:0] req;
    logic [1:0]                    idx;
    cfg_t                          cfg_prev_q;
    logic                          inject;
    flit_t                         eject_flit_d;
    logic [DATA_W-1:0]             eject_data_d;

    assign local_empty_c = !buf_q[IN_LOCAL].valid;
    assign x_empty_c     = !buf_q[IN_X].valid;
    assign y_empty_c     = !buf_q[IN_Y].valid;

    // Requests and round-robin grants; neighbour buffers are judged at cycle start
    always_comb begin
        out_ready            = '0;
        out_ready[OUT_X]     = x_nb_empty;
        out_ready[OUT_Y]     = y_nb_empty;
        out_ready[OUT_EJECT] = 1'b1;
        req       = '0;
        gnt_valid = '0;
        idx       = '0;
        for (int o = 0; o < NUM_OUT; o++) begin
            gnt_idx[o] = '0;
            ptr_d[o]   = ptr_q[o];
            for (int i = 0; i < NUM_IN; i++) begin
                req[o][i] = !block && buf_q[i].valid && out_ready[o]
                            && (xy_route(NODE_ID, buf_q[i].dest) == 2'(o));
            end
            for (int k = 0; k < NUM_IN; k++) begin
                idx = ptr_q[o] + 2'(k);
                if (!gnt_valid[o] && req[o][idx]) begin
                    gnt_valid[o] = 1'b1;
                    gnt_idx[o]   = idx;
                end
            end
            if (gnt_valid[o]) ptr_d[o] = gnt_idx[o] + 2'd1;
        end
    end

    // Buffer next state, link outputs and ejection
    always_comb begin
        inject = (cfg != '0) && (cfg != cfg_prev_q) && !buf_q[IN_LOCAL].valid && !block;
        for (int i = 0; i < NUM_IN; i++) buf_d[i] = buf_q[i];
        for (int o = 0; o < NUM_OUT; o++) begin
            if (gnt_valid[o]) buf_d[gnt_idx[o]] = '0;
        end
        if (inject) begin
            buf_d[IN_LOCAL] = '{valid: 1'b1, src: NODE_ID, dest: cfg.dest,
                                rsv: '0, data: cfg.data};
        end
        if (ext_in.valid && !buf_q[IN_EXT].valid && !block) buf_d[IN_EXT] = ext_in;
        if (x_in_load) buf_d[IN_X] = x_in;
        if (y_in_load) buf_d[IN_Y] = y_in;

        x_out_c      = buf_q[gnt_idx[OUT_X]];
        x_out_load_c = gnt_valid[OUT_X];
        y_out_c      = buf_q[gnt_idx[OUT_Y]];
        y_out_load_c = gnt_valid[OUT_Y];

        eject_flit_d = '0;
        eject_data_d = eject_data;
        if (gnt_valid[OUT_EJECT]) begin
            eject_flit_d = buf_q[gnt_idx[OUT_EJECT]];
            eject_data_d = buf_q[gnt_idx[OUT_EJECT]].data;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < NUM_IN; i++) buf_q[i] <= '0;
            for (int o = 0; o < NUM_OUT; o++) ptr_q[o] <= IN_LOCAL;
            cfg_prev_q <= '0;
            eject_data <= '0;
            eject_flit <= '0;
        end else begin
            for (int i = 0; i < NUM_IN; i++) buf_q[i] <= buf_d[i];
            for (int o = 0; o < NUM_OUT; o++) ptr_q[o] <= ptr_d[o];
            cfg_prev_q <= cfg;
            eject_data <= eject_data_d;
            eject_flit <= eject_flit_d;
        end
    end

endmodule

// File: rtl/mesh_2x2.sv
// 2x2 mesh: four routers, X links between n and n^1, Y links between n and n^2.
module mesh_2x2
    import noc_pkg::*;
(
    input logic       clock,
    input logic       reset,
    mesh_2x2_if.slave bus
);

    flit_t             ext_in      [NUM_NODES];
    cfg_t              cfg         [NUM_NODES];
    flit_t             x_link      [NUM_NODES];
    flit_t             y_link      [NUM_NODES];
    logic              x_load      [NUM_NODES];
    logic              y_load      [NUM_NODES];
    logic              x_empty     [NUM_NODES];
    logic              y_empty     [NUM_NODES];
    logic              local_empty [NUM_NODES];
    logic [DATA_W-1:0] rx_data     [NUM_NODES];
    flit_t             eject_flit  [NUM_NODES];
    logic [NUM_NODES-1:0] ready;

    assign ext_in[0] = bus.r0_input;
    assign ext_in[1] = bus.r1_input;
    assign ext_in[2] = bus.r2_input;
    assign ext_in[3] = bus.r3_input;
    assign cfg[0]    = bus.p0_configure;
    assign cfg[1]    = bus.p1_configure;
    assign cfg[2]    = bus.p2_configure;
    assign cfg[3]    = bus.p3_configure;

    for (genvar n = 0; n < NUM_NODES; n++) begin : g_router
        localparam int XN = n ^ 1;
        localparam int YN = n ^ 2;

        noc_router #(
            .NODE_ID(NODE_W'(n))
        ) u_router (
            .clock         (clock),
            .reset         (reset),
            .block         (bus.block_all_paths),
            .cfg           (cfg[n]),
            .ext_in        (ext_in[n]),
            .x_in          (x_link[XN]),
            .x_in_load     (x_load[XN]),
            .y_in          (y_link[YN]),
            .y_in_load     (y_load[YN]),
            .x_nb_empty    (x_empty[XN]),
            .y_nb_empty    (y_empty[YN]),
            .x_out_c       (x_link[n]),
            .x_out_load_c  (x_load[n]),
            .y_out_c       (y_link[n]),
            .y_out_load_c  (y_load[n]),
            .local_empty_c (local_empty[n]),
            .x_empty_c     (x_empty[n]),
            .y_empty_c     (y_empty[n]),
            .eject_data    (rx_data[n]),
            .eject_flit    (eject_flit[n])
        );
    end

    // Ready tracks the global stall directly so a sender sees it in the same cycle
    always_comb begin
        ready = '0;
        for (int n = 0; n < NUM_NODES; n++) begin
            ready[n] = local_empty[n] && !bus.block_all_paths;
        end
    end

    assign bus.processor_ready_signals = ready;
    assign bus.p0_recieve_data         = rx_data[0];
    assign bus.p1_recieve_data         = rx_data[1];
    assign bus.p2_recieve_data         = rx_data[2];
    assign bus.p3_recieve_data         = rx_data[3];
    assign bus.r0_output               = eject_flit[0];
    assign bus.r1_output               = eject_flit[1];
    assign bus.r2_output               = eject_flit[2];
    assign bus.r3_output               = eject_flit[3];

endmodule

// File: tb/tb_mesh_2x2.sv
// Directed bench for mesh_2x2: injection, loopback, XY routing, external
// input, global stall, drop on full buffer and reset flush.
module tb_mesh_2x2;
    import noc_pkg::*;

    logic clock = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clock = ~clock;

    mesh_2x2_if bus ();

    mesh_2x2 dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    function automatic logic [17:0] mk_flit(input logic [1:0] src, input logic [1:0] dest,
                                            input logic [8:0] data);
        return {1'b1, src, dest, 4'b0000, data};
    endfunction

    task automatic step(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs;
        bus.r0_input = '0; bus.r1_input = '0; bus.r2_input = '0; bus.r3_input = '0;
        bus.p0_configure = '0; bus.p1_configure = '0;
        bus.p2_configure = '0; bus.p3_configure = '0;
        bus.block_all_paths = 1'b0;
    endtask

    task automatic test_reset;
        idle_inputs();
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        n_checks++;
        if ({bus.r0_output, bus.r1_output, bus.r2_output, bus.r3_output} !== 72'h0) begin
            n_fail++;
            $display("FAIL reset_rout: got %h %h %h %h required 0", bus.r0_output,
                     bus.r1_output, bus.r2_output, bus.r3_output);
        end
        n_checks++;
        if ({bus.p0_recieve_data, bus.p1_recieve_data, bus.p2_recieve_data,
             bus.p3_recieve_data} !== 36'h0) begin
            n_fail++;
            $display("FAIL reset_rx: got %h %h %h %h required 0", bus.p0_recieve_data,
                     bus.p1_recieve_data, bus.p2_recieve_data, bus.p3_recieve_data);
        end
        n_checks++;
        if (bus.processor_ready_signals !== 4'b1111) begin
            n_fail++;
            $display("FAIL reset_ready: got %b required 1111", bus.processor_ready_signals);
        end
        bus.block_all_paths = 1'b1;
        #1;
        n_checks++;
        if (bus.processor_ready_signals !== 4'b0000) begin
            n_fail++;
            $display("FAIL block_ready: got %b required 0000", bus.processor_ready_signals);
        end
        bus.block_all_paths = 1'b0;
        #1;
    endtask

    task automatic test_single;
        int extra = 0;
        bus.p0_configure = 11'b01000000101;
        step(1);
        n_checks++;
        if (bus.processor_ready_signals !== 4'b1110) begin
            n_fail++;
            $display("FAIL single_ready: got %b required 1110", bus.processor_ready_signals);
        end
        step(1);
        n_checks++;
        if (bus.r1_output !== 18'h0) begin
            n_fail++;
            $display("FAIL single_early: got %h required 0", bus.r1_output);
        end
        step(1);
        bus.p0_configure = '0;
        n_checks++;
        if (bus.p1_recieve_data !== 9'd5) begin
            n_fail++;
            $display("FAIL single_rx: got %h required %h", bus.p1_recieve_data, 9'd5);
        end
        n_checks++;
        if (bus.r1_output !== mk_flit(2'd0, 2'd1, 9'd5)) begin
            n_fail++;
            $display("FAIL single_rout: got %h required %h", bus.r1_output,
                     mk_flit(2'd0, 2'd1, 9'd5));
        end
        for (int c = 0; c < 4; c++) begin
            step(1);
            if (bus.r1_output !== 18'h0) extra++;
        end
        n_checks++;
        if (extra !== 0) begin
            n_fail++;
            $display("FAIL single_once: got %0d extra ejections required 0", extra);
        end
        n_checks++;
        if (bus.p1_recieve_data !== 9'd5) begin
            n_fail++;
            $display("FAIL single_hold: got %h required %h", bus.p1_recieve_data, 9'd5);
        end
    endtask

    task automatic test_loopback;
        bus.p1_configure = 11'b01000000001;
        bus.p3_configure = 11'b01000000001;
        step(1);
        bus.p1_configure = '0;
        bus.p3_configure = '0;
        n_checks++;
        if (bus.processor_ready_signals !== 4'b0101) begin
            n_fail++;
            $display("FAIL loop_ready: got %b required 0101", bus.processor_ready_signals);
        end
        step(1);
        n_checks++;
        if (bus.r1_output !== mk_flit(2'd1, 2'd1, 9'd1) || bus.p1_recieve_data !== 9'd1) begin
            n_fail++;
            $display("FAIL loop_local: got %h/%h required %h/%h", bus.r1_output,
                     bus.p1_recieve_data, mk_flit(2'd1, 2'd1, 9'd1), 9'd1);
        end
        step(1);
        n_checks++;
        if (bus.r1_output !== mk_flit(2'd3, 2'd1, 9'd1) || bus.p1_recieve_data !== 9'd1) begin
            n_fail++;
            $display("FAIL loop_ylink: got %h/%h required %h/%h", bus.r1_output,
                     bus.p1_recieve_data, mk_flit(2'd3, 2'd1, 9'd1), 9'd1);
        end
        step(1);
        n_checks++;
        if (bus.r1_output !== 18'h0 || bus.r3_output !== 18'h0) begin
            n_fail++;
            $display("FAIL loop_after: got %h %h required 0 0", bus.r1_output, bus.r3_output);
        end
    endtask

    task automatic test_corner;
        bus.p0_configure = {2'd3, 9'h1FF};
        step(1);
        bus.p0_configure = '0;
        for (int c = 1; c <= 2; c++) begin
            step(1);
            n_checks++;
            if ({bus.r0_output, bus.r1_output, bus.r2_output, bus.r3_output} !== 72'h0) begin
                n_fail++;
                $display("FAIL corner_transit k+%0d: got %h %h %h %h required 0", c,
                         bus.r0_output, bus.r1_output, bus.r2_output, bus.r3_output);
            end
        end
        step(1);
        n_checks++;
        if (bus.p3_recieve_data !== 9'h1FF || bus.r3_output !== mk_flit(2'd0, 2'd3, 9'h1FF)) begin
            n_fail++;
            $display("FAIL corner_rx: got %h/%h required %h/%h", bus.p3_recieve_data,
                     bus.r3_output, 9'h1FF, mk_flit(2'd0, 2'd3, 9'h1FF));
        end
        step(1);
    endtask

    task automatic test_external;
        bus.r2_input = mk_flit(2'd2, 2'd1, 9'd7);
        step(1);
        bus.r2_input = '0;
        n_checks++;
        if (bus.processor_ready_signals !== 4'b1111) begin
            n_fail++;
            $display("FAIL ext_ready: got %b required 1111", bus.processor_ready_signals);
        end
        step(2);
        n_checks++;
        if (bus.r1_output !== 18'h0 || bus.r3_output !== 18'h0) begin
            n_fail++;
            $display("FAIL ext_early: got %h %h required 0 0", bus.r1_output, bus.r3_output);
        end
        step(1);
        n_checks++;
        if (bus.p1_recieve_data !== 9'd7 || bus.r1_output !== mk_flit(2'd2, 2'd1, 9'd7)) begin
            n_fail++;
            $display("FAIL ext_rx: got %h/%h required %h/%h", bus.p1_recieve_data,
                     bus.r1_output, 9'd7, mk_flit(2'd2, 2'd1, 9'd7));
        end
        step(1);
    endtask

    task automatic test_block;
        bus.p0_configure = {2'd1, 9'h0AA};
        step(1);
        bus.p0_configure = '0;
        bus.block_all_paths = 1'b1;
        for (int c = 1; c <= 5; c++) begin
            step(1);
            n_checks++;
            if (bus.r1_output !== 18'h0 || bus.processor_ready_signals !== 4'b0000) begin
                n_fail++;
                $display("FAIL block_hold k+%0d: got %h/%b required 0/0000", c,
                         bus.r1_output, bus.processor_ready_signals);
            end
        end
        n_checks++;
        if (bus.p1_recieve_data !== 9'd7) begin
            n_fail++;
            $display("FAIL block_rx_hold: got %h required %h", bus.p1_recieve_data, 9'd7);
        end
        bus.block_all_paths = 1'b0;
        #1;
        n_checks++;
        if (bus.processor_ready_signals !== 4'b1110) begin
            n_fail++;
            $display("FAIL block_release: got %b required 1110", bus.processor_ready_signals);
        end
        step(1);
        n_checks++;
        if (bus.r1_output !== 18'h0) begin
            n_fail++;
            $display("FAIL block_early: got %h required 0", bus.r1_output);
        end
        step(1);
        n_checks++;
        if (bus.p1_recieve_data !== 9'h0AA || bus.r1_output !== mk_flit(2'd0, 2'd1, 9'h0AA)) begin
            n_fail++;
            $display("FAIL block_rx: got %h/%h required %h/%h", bus.p1_recieve_data,
                     bus.r1_output, 9'h0AA, mk_flit(2'd0, 2'd1, 9'h0AA));
        end
        step(1);
    endtask

    task automatic test_drop;
        int extra = 0;
        bus.p0_configure = {2'd1, 9'h011};
        step(1);
        bus.p0_configure = {2'd1, 9'h022};
        step(2);
        n_checks++;
        if (bus.p1_recieve_data !== 9'h011 || bus.r1_output !== mk_flit(2'd0, 2'd1, 9'h011)) begin
            n_fail++;
            $display("FAIL drop_first: got %h/%h required %h/%h", bus.p1_recieve_data,
                     bus.r1_output, 9'h011, mk_flit(2'd0, 2'd1, 9'h011));
        end
        step(1);
        bus.p0_configure = '0;
        if (bus.r1_output !== 18'h0) extra++;
        for (int c = 0; c < 3; c++) begin
            step(1);
            if (bus.r1_output !== 18'h0) extra++;
        end
        n_checks++;
        if (extra !== 0 || bus.p1_recieve_data !== 9'h011) begin
            n_fail++;
            $display("FAIL drop_second: got %0d ejections, rx %h required 0, %h", extra,
                     bus.p1_recieve_data, 9'h011);
        end
    endtask

    task automatic test_reset_flush;
        int extra = 0;
        bus.p0_configure = {2'd1, 9'h033};
        step(1);
        reset = 1'b1;
        bus.block_all_paths = 1'b1;
        bus.p0_configure = '0;
        step(1);
        reset = 1'b0;
        bus.block_all_paths = 1'b0;
        #1;
        n_checks++;
        if (bus.processor_ready_signals !== 4'b1111 || bus.p1_recieve_data !== 9'd0) begin
            n_fail++;
            $display("FAIL flush_state: got %b/%h required 1111/000",
                     bus.processor_ready_signals, bus.p1_recieve_data);
        end
        for (int c = 0; c < 4; c++) begin
            step(1);
            if (bus.r1_output !== 18'h0 || bus.p1_recieve_data !== 9'd0) extra++;
        end
        n_checks++;
        if (extra !== 0) begin
            n_fail++;
            $display("FAIL flush_discard: got %0d late deliveries required 0", extra);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_loopback();
        test_corner();
        test_external();
        test_block();
        test_drop();
        test_reset_flush();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
